multicycle_controller: RTL

- Control unit for the multi-cycle RV32I datapath.
- Consumes the decoded instruction fields and the ALU Zero flag from the datapath, and drives every datapath control strobe.
- Moore main FSM plus combinational ALU decoder and immediate-type decoder.
- Latches op/funct3/funct7b5 at instruction fetch, so decode never depends on live memory output after PC has advanced.

---
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The controller uses the master modport; the datapath uses the slave modport.
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [2:0] ALUControl;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUSrcA;
   logic [1:0] ImmSrc;
   logic       RegWrite;
   logic       Illegal;

   modport master (
      input  op, funct3, funct7b5, Zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
             ALUSrcB, ALUSrcA, ImmSrc, RegWrite, Illegal
   );

   modport slave (
      output op, funct3, funct7b5, Zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
             ALUSrcB, ALUSrcA, ImmSrc, RegWrite, Illegal
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: Moore main FSM, ALU decoder, immediate-type decoder.
// Define MC_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of skipping them.
module multicycle_controller #(
   parameter bit LATCH_IR = 1'b1
) (
   input logic                       clk,
   input logic                       reset,
   multicycle_controller_if.master   bus
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
   } state_t;

   state_t     state, state_next;
   logic [6:0] op_q;
   logic [2:0] funct3_q;
   logic       funct7b5_q;
   logic [6:0] dec_op;
   logic [2:0] dec_funct3;
   logic       dec_funct7b5;

   logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] alu_op, result_src, alu_src_a, alu_src_b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= FETCH;
         op_q       <= '0;
         funct3_q   <= '0;
         funct7b5_q <= 1'b0;
      end else begin
         state <= state_next;
         if (ir_write) begin
            op_q       <= bus.op;
            funct3_q   <= bus.funct3;
            funct7b5_q <= bus.funct7b5;
         end
      end
   end

   // Decode from fields captured in FETCH so a moving PC cannot corrupt decode.
   assign dec_op       = LATCH_IR ? op_q       : bus.op;
   assign dec_funct3   = LATCH_IR ? funct3_q   : bus.funct3;
   assign dec_funct7b5 = LATCH_IR ? funct7b5_q : bus.funct7b5;

   always_comb begin
      state_next = state;
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      alu_op     = 2'b00;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      unique case (state)
         FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_update  = 1'b1;
            state_next = DECODE;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (dec_op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECR;
               OP_I:         state_next = EXECI;
               OP_BEQ:       state_next = BEQ;
               OP_JAL:       state_next = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
               default:      state_next = TRAP;
`else
               default:      state_next = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            if (dec_op == OP_LW)      state_next = MEMREAD;
            else if (dec_op == OP_SW) state_next = MEMWRITE;
            else                      state_next = FETCH;
         end
         MEMREAD: begin
            adr_src    = 1'b1;
            state_next = MEMWB;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            state_next = FETCH;
         end
         EXECR: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b10;
            state_next = ALUWB;
         end
         EXECI: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            alu_op     = 2'b10;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         BEQ: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            branch     = 1'b1;
            state_next = FETCH;
         end
         JAL: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pc_update  = 1'b1;
            state_next = ALUWB;
         end
         TRAP: state_next = TRAP;
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
      bus.ALUControl = 3'b000;
      case (alu_op)
         2'b01: bus.ALUControl = 3'b001;
         2'b10: begin
            case (dec_funct3)
               3'b000:  bus.ALUControl = (dec_op[5] & dec_funct7b5) ? 3'b001 : 3'b000;
               3'b010:  bus.ALUControl = 3'b101;
               3'b110:  bus.ALUControl = 3'b011;
               3'b111:  bus.ALUControl = 3'b010;
               default: bus.ALUControl = 3'b000;
            endcase
         end
         default: bus.ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      case (dec_op)
         OP_SW:   bus.ImmSrc = 2'b01;
         OP_BEQ:  bus.ImmSrc = 2'b10;
         OP_JAL:  bus.ImmSrc = 2'b11;
         default: bus.ImmSrc = 2'b00;
      endcase
   end

   // Enables are gated by reset so an async reset kills writes within the cycle.
   assign bus.PCWrite   = reset & (pc_update | (branch & bus.Zero));
   assign bus.MemWrite  = reset & mem_write;
   assign bus.IRWrite   = reset & ir_write;
   assign bus.RegWrite  = reset & reg_write;
   assign bus.AdrSrc    = adr_src;
   assign bus.ResultSrc = result_src;
   assign bus.ALUSrcA   = alu_src_a;
   assign bus.ALUSrcB   = alu_src_b;

`ifdef MC_ILLEGAL_TRAP_EN
   assign bus.Illegal = (state == TRAP);
`else
   assign bus.Illegal = 1'b0;
`endif

endmodule
